// File: rtl/pep_ks_cmd_sched.sv
// KS command scheduler: buffers sequencer commands and issues one per key-switch
// enquiry while a KSK pass slot is free; supports an orderly flush on reset_cache.
module pep_ks_cmd_sched #(
    parameter int CMD_W        = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_INFLIGHT = 2,
    parameter int ENQ_MAX      = 7
) (
    input  logic             clk,
    input  logic             s_rst,
    input  logic [CMD_W-1:0] seq_cmd,
    input  logic             seq_cmd_vld,
    output logic             seq_cmd_rdy,
    input  logic             ks_seq_cmd_enquiry,
    output logic [CMD_W-1:0] seq_ks_cmd,
    output logic             seq_ks_cmd_avail,
    input  logic             inc_ksk_rd_ptr,
    input  logic             reset_cache,
    output logic             flush_done,
    output logic [3:0]       inflight_cnt,
    output logic [2:0]       sched_error
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = $clog2(ENQ_MAX + 1);

    localparam logic [CW-1:0] DEPTH_V   = CW'(FIFO_DEPTH);
    localparam logic [3:0]    MAX_IF_V  = 4'(MAX_INFLIGHT);
    localparam logic [EW-1:0] ENQ_MAX_V = EW'(ENQ_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CMD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    fifo_cnt;
    logic [EW-1:0]    enq_cnt;
    logic [3:0]       inflight;
    logic             flush_pend;
    logic [CMD_W-1:0] cmd_q;
    logic [2:0]       err_q;

    logic fifo_empty, fifo_full, fifo_wr;
    logic has_credit, has_work, can_issue, issue, flush_exit;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == DEPTH_V);
    assign has_credit = (inflight < MAX_IF_V);
    assign has_work   = (enq_cnt != '0) && !fifo_empty;
    assign can_issue  = has_work && has_credit && (state == ST_IDLE);
    assign issue      = (state == ST_ISSUE);
    assign flush_exit = (state == ST_FLUSH) && (inflight == 4'd0);
    assign fifo_wr    = seq_cmd_vld && seq_cmd_rdy;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (s_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (reset_cache || flush_pend) state_nxt = ST_FLUSH;
                else if (can_issue)            state_nxt = ST_ISSUE;
                else if (has_work)             state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (reset_cache)     state_nxt = ST_FLUSH;
                else if (has_credit) state_nxt = ST_IDLE;
            end
            ST_ISSUE: state_nxt = ST_IDLE;
            ST_FLUSH: if (inflight == 4'd0) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // A full FIFO still accepts a write in the cycle its head is popped.
    always_comb begin
        seq_cmd_rdy      = !s_rst && (!fifo_full || issue) && (state != ST_FLUSH);
        seq_ks_cmd_avail = issue;
        flush_done       = flush_exit;
    end

    assign seq_ks_cmd   = cmd_q;
    assign inflight_cnt = inflight;
    assign sched_error  = err_q;

    // NOTE: the storage array is not reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr] <= seq_cmd;
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            enq_cnt    <= '0;
            inflight   <= '0;
            flush_pend <= 1'b0;
            cmd_q      <= '0;
            err_q      <= '0;
        end else begin
            if (issue && reset_cache)        flush_pend <= 1'b1;
            else if (state_nxt == ST_FLUSH)  flush_pend <= 1'b0;

            // Latch the head on the decision edge so the output is held after issue.
            if (state_nxt == ST_ISSUE) cmd_q <= mem[rd_ptr];

            if (flush_exit) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
                if (issue)   rd_ptr <= rd_ptr + 1'b1;
                case ({fifo_wr, issue})
                    2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                    2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                    default: fifo_cnt <= fifo_cnt;
                endcase
            end

            // An enquiry at saturation is dropped even if an issue coincides.
            if (flush_exit) begin
                enq_cnt <= '0;
            end else begin
                case ({ks_seq_cmd_enquiry, issue})
                    2'b10:   if (enq_cnt != ENQ_MAX_V) enq_cnt <= enq_cnt + 1'b1;
                    2'b01:   enq_cnt <= enq_cnt - 1'b1;
                    2'b11:   if (enq_cnt == ENQ_MAX_V) enq_cnt <= enq_cnt - 1'b1;
                    default: enq_cnt <= enq_cnt;
                endcase
            end

            case ({issue, inc_ksk_rd_ptr})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   if (inflight != 4'd0) inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase

            if (inc_ksk_rd_ptr && !issue && (inflight == 4'd0)) err_q[0] <= 1'b1;
            if (ks_seq_cmd_enquiry && (enq_cnt == ENQ_MAX_V))    err_q[1] <= 1'b1;
            if (seq_cmd_vld && (state == ST_FLUSH))              err_q[2] <= 1'b1;
        end
    end

endmodule
